// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
interface program_loader_if #(parameter int PC_SIZE = 10);
  logic                load_req;
  logic [7:0]          byte_in;
  logic                byte_valid;
  logic                byte_ready;
  logic                mem_write_en;
  logic [PC_SIZE-1:0]  PC_write;
  logic [31:0]         instruction_in;
  logic                core_reset;
  logic                load_done;
  logic                load_error;

  modport master (
    output load_req, byte_in, byte_valid,
    input  byte_ready, mem_write_en, PC_write, instruction_in,
           core_reset, load_done, load_error
  );

  modport slave (
    input  load_req, byte_in, byte_valid,
    output byte_ready, mem_write_en, PC_write, instruction_in,
           core_reset, load_done, load_error
  );
endinterface

// File: rtl/program_loader.sv
// Loads a length-prefixed little-endian instruction stream into fetch-stage
// instruction memory, holding the core in reset until the load completes.
module program_loader #(
  parameter int PC_SIZE = 10
) (
  input  logic             clock,
  input  logic             reset,
  program_loader_if.slave  bus
);
  localparam logic [16:0] DEPTH = 17'd1 << PC_SIZE;

  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, BYTES, WRITE, DONE, ERROR} state_t;

  state_t      state, next;
  logic [15:0] count;
  logic [15:0] word_idx;
  logic [1:0]  byte_sel;
  logic [31:0] instr;
  logic        hs;
  logic [15:0] len_full;
  logic [15:0] idx_next;

  assign hs       = bus.byte_valid & bus.byte_ready;
  assign len_full = {bus.byte_in, count[7:0]};
  assign idx_next = word_idx + 16'd1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE:   if (bus.load_req) next = LEN_LO;
      LEN_LO: if (hs) next = LEN_HI;
      LEN_HI: if (hs) begin
        // 17-bit compare so a count of exactly DEPTH is legal
        if ({1'b0, len_full} > DEPTH) next = ERROR;
        else if (len_full == 16'd0)   next = DONE;
        else                          next = BYTES;
      end
      BYTES:  if (hs && byte_sel == 2'd3) next = WRITE;
      WRITE:  next = (idx_next == count) ? DONE : BYTES;
      DONE,
      ERROR:  if (bus.load_req) next = LEN_LO;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count    <= '0;
      word_idx <= '0;
      byte_sel <= '0;
      instr    <= '0;
    end else begin
      case (state)
        LEN_LO: if (hs) count[7:0] <= bus.byte_in;
        LEN_HI: if (hs) begin
          count[15:8] <= bus.byte_in;
          word_idx    <= '0;
          byte_sel    <= '0;
        end
        BYTES: if (hs) begin
          instr[8*byte_sel +: 8] <= bus.byte_in;
          byte_sel               <= byte_sel + 2'd1;
        end
        WRITE: word_idx <= idx_next;
        default: ;
      endcase
    end
  end

  // Every output comes from state or registers, never straight from inputs.
  assign bus.byte_ready     = (state == LEN_LO) || (state == LEN_HI) || (state == BYTES);
  assign bus.mem_write_en   = (state == WRITE);
  assign bus.PC_write       = word_idx[PC_SIZE-1:0];
  assign bus.instruction_in = instr;
  assign bus.core_reset     = (state != DONE);
  assign bus.load_done      = (state == DONE);
  assign bus.load_error     = (state == ERROR);
endmodule

// File: tb/tb_program_loader.sv
// Directed + randomized bench for program_loader with a word-level memory model.
module tb_program_loader;
  localparam int PC_SIZE = 10;
  localparam int DEPTH   = 1 << PC_SIZE;

  logic clock = 1'b0;
  logic reset;

  program_loader_if #(.PC_SIZE(PC_SIZE)) bus();
  program_loader #(.PC_SIZE(PC_SIZE)) dut (.clock(clock), .reset(reset), .bus(bus.slave));

  always #5 clock = ~clock;

  typedef struct packed {
    logic [PC_SIZE-1:0] addr;
    logic [31:0]        data;
  } wr_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] cap_mem [DEPTH] = '{default: 32'h0};
  logic [31:0] exp_mem [DEPTH] = '{default: 32'h0};
  wr_t         wr_q [$];
  logic [31:0] prog [$];
  bit          in_load = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Observed memory: whatever the DUT strobes in on each rising edge.
  always @(posedge clock) begin
    if (bus.mem_write_en === 1'b1) begin
      cap_mem[bus.PC_write] <= bus.instruction_in;
      wr_q.push_back('{addr: bus.PC_write, data: bus.instruction_in});
    end
  end

  // While a load is in flight, the only non-accepting cycles are write cycles.
  always @(negedge clock) begin
    if (in_load && reset === 1'b0 && bus.load_done !== 1'b1 && bus.load_error !== 1'b1)
      chk("ready_vs_write", bus.byte_ready, !bus.mem_write_en);
  end

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_byte_ready"}, bus.byte_ready, 0);
    chk({pfx, "_mem_write_en"}, bus.mem_write_en, 0);
    chk({pfx, "_PC_write"}, bus.PC_write, 0);
    chk({pfx, "_instruction_in"}, bus.instruction_in, 0);
    chk({pfx, "_core_reset"}, bus.core_reset, 1);
    chk({pfx, "_load_done"}, bus.load_done, 0);
    chk({pfx, "_load_error"}, bus.load_error, 0);
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n  = 0;
    bit ok = 1'b0;
    bus.byte_valid = 1'b0;
    repeat (gap) begin @(posedge clock); #1; end
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    while (!ok && n < 40) begin
      @(negedge clock);
      ok = (bus.byte_ready === 1'b1);
      @(posedge clock); #1;
      n++;
    end
    bus.byte_valid = 1'b0;
    chk("handshake_timeout", ok, 1);
  endtask

  task automatic start_load();
    bus.load_req = 1'b1;
    @(posedge clock); #1;
    bus.load_req = 1'b0;
    in_load = 1'b1;
    chk("start_core_reset", bus.core_reset, 1);
    chk("start_load_done", bus.load_done, 0);
    chk("start_load_error", bus.load_error, 0);
  endtask

  task automatic do_load(input logic [15:0] cnt, input int maxgap);
    wr_t exp_q [$];
    // Reference: a legal load writes words 0..cnt-1 with the program words.
    if (int'(cnt) <= DEPTH)
      for (int i = 0; i < int'(cnt); i++) begin
        exp_q.push_back('{addr: PC_SIZE'(i), data: prog[i]});
        exp_mem[i] = prog[i];
      end
    wr_q.delete();
    start_load();
    send_byte(cnt[7:0],  $urandom_range(maxgap));
    send_byte(cnt[15:8], $urandom_range(maxgap));
    if (int'(cnt) > DEPTH) begin
      chk("err_load_error", bus.load_error, 1);
      chk("err_core_reset", bus.core_reset, 1);
      chk("err_load_done", bus.load_done, 0);
    end else if (cnt == 16'd0) begin
      chk("zero_load_done", bus.load_done, 1);
      chk("zero_core_reset", bus.core_reset, 0);
      chk("zero_mem_write_en", bus.mem_write_en, 0);
    end else begin
      for (int i = 0; i < int'(cnt); i++) begin
        for (int j = 0; j < 4; j++) send_byte(prog[i][8*j +: 8], $urandom_range(maxgap));
        chk("wr_strobe", bus.mem_write_en, 1);
        chk("wr_addr", bus.PC_write, i);
        chk("wr_data", bus.instruction_in, prog[i]);
      end
      @(posedge clock); #1;
      chk("end_load_done", bus.load_done, 1);
      chk("end_core_reset", bus.core_reset, 0);
      chk("end_load_error", bus.load_error, 0);
    end
    in_load = 1'b0;
    chk("n_writes", wr_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      chk("wlog_addr", wr_q[i].addr, exp_q[i].addr);
      chk("wlog_data", wr_q[i].data, exp_q[i].data);
    end
    for (int k = 0; k < DEPTH; k++) chk("mem", cap_mem[k], exp_mem[k]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    reset          = 1'b1;
    bus.load_req   = 1'b0;
    bus.byte_in    = 8'h00;
    bus.byte_valid = 1'b0;
    @(negedge clock);
    chk_reset_vals("rst");
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Two-word program, continuous then gappy valid
    prog = '{32'h00000013, 32'h00100093};
    do_load(16'd2, 0);
    do_load(16'd2, 3);

    // Empty program
    do_load(16'd0, 1);

    // Oversize count, then recover with a one-word load (word 1 must survive)
    do_load(16'h0401, 0);
    prog = '{$urandom()};
    do_load(16'd1, 2);

    // Full-depth load
    prog.delete();
    for (int i = 0; i < DEPTH; i++) prog.push_back($urandom());
    do_load(16'h0400, 0);

    // Short random program with random gaps
    prog.delete();
    for (int i = 0; i < 5; i++) prog.push_back($urandom());
    do_load(16'd5, 3);

    // Reset in the write cycle of the first word: nothing may be written
    prog = '{$urandom(), $urandom()};
    start_load();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    for (int j = 0; j < 4; j++) send_byte(prog[0][8*j +: 8], 0);
    in_load = 1'b0;
    reset = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    @(posedge clock); #1;
    reset = 1'b0;
    for (int k = 0; k < DEPTH; k++) chk("mem_after_rst", cap_mem[k], exp_mem[k]);
    do_load(16'd2, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/program_loader.md
# program_loader

Upstream feeder of the fetch stage's instruction memory. Accepts a byte stream (valid/ready) carrying a 16-bit word count followed by little-endian 32-bit instructions. Assembles each instruction and writes it into instruction memory through the fetch stage's write port (`reset_memory`, `PC_write`, `instruction_in`). Holds the core in reset until the whole program is loaded.

## Interface
Parameters:
- `PC_SIZE`, default 10: instruction address width; memory depth `DEPTH` = 2^PC_SIZE words.

Ports:
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state immediately.
- `load_req`  in  1: level; starts a load when sampled high in IDLE, DONE or ERROR.
- `byte_in`  in  8: stream data.
- `byte_valid`  in  1: `byte_in` is valid this cycle.
- `byte_ready`  out  1: loader accepts a byte this cycle.
- `mem_write_en`  out  1: drives the fetch stage's `reset_memory`; one-cycle write strobe.
- `PC_write`  out  PC_SIZE: instruction memory write address (word index).
- `instruction_in`  out  32: assembled instruction to write.
- `core_reset`  out  1: holds the CPU in reset while high.
- `load_done`  out  1: program loaded; core released.
- `load_error`  out  1: the word count exceeded `DEPTH`.

## Operation
- A handshake occurs on a rising edge where `byte_valid & byte_ready`. `byte_valid` may be high with `byte_ready` low; the byte is then held by the source and not consumed.
- States are IDLE, LEN_LO, LEN_HI, BYTES, WRITE, DONE and ERROR. Reset enters IDLE.
- IDLE: `core_reset=1`, `byte_ready=0`. `load_req=1` moves to LEN_LO.
- LEN_LO: `byte_ready=1`. On handshake, `count[7:0]=byte_in`, then go to LEN_HI.
- LEN_HI: `byte_ready=1`. On handshake, `count[15:8]=byte_in`, `word_idx=0`, `byte_sel=0`. Next state:
  - ERROR if the 16-bit count > `DEPTH`.
  - DONE if count == 0.
  - Otherwise BYTES.
- BYTES: `byte_ready=1`.
  - Each handshake stores `byte_in` into `instruction_in[8*byte_sel +: 8]`; `byte_sel` increments mod 4.
  - A handshake with `byte_sel==3` goes to WRITE.
- WRITE: `byte_ready=0`, `mem_write_en=1`, `PC_write=word_idx`.
  - Next edge: `word_idx` increments.
  - Go to DONE if `word_idx+1 == count`, else back to BYTES.
  - The comparison is 16-bit, so `count == DEPTH` ends correctly. `PC_write` is the low PC_SIZE bits of `word_idx` and never wraps in a legal load.
- DONE: `core_reset=0`, `load_done=1`, `byte_ready=0`. `load_req=1` restarts at LEN_LO, reasserting `core_reset` and clearing `load_done`.
- ERROR: `core_reset=1`, `load_error=1`, `byte_ready=0`. Nothing is written. `load_req=1` restarts at LEN_LO and clears `load_error`.
- `load_req` is ignored in LEN_LO, LEN_HI, BYTES and WRITE.
- A restarted load overwrites words 0..count-1. Words beyond that keep their old contents.
- All outputs are registered or decoded from state only; no combinational path from inputs to outputs.

## Timing
- Reset values: state IDLE, `byte_ready=0`, `mem_write_en=0`, `PC_write=0`, `instruction_in=0`, `core_reset=1`, `load_done=0`, `load_error=0`, counters 0.
- Byte throughput: one byte per cycle in LEN_LO, LEN_HI and BYTES. Each word costs 4 accept cycles plus 1 WRITE cycle, so sustained rate is 5 cycles/word.
- Write latency: the 4th byte of a word is accepted at edge k. `mem_write_en=1` during cycle k+1 with stable `PC_write` and `instruction_in`. Memory captures at edge k+1.
- The final write is at edge k+1. `core_reset` falls and `load_done` rises in the cycle after that edge (state DONE).
- Length check: the high length byte is accepted at edge k. ERROR or DONE is visible from cycle k+1.
- `reset` asserted mid-load: immediate return to IDLE with all reset values. A partially loaded memory is not cleared. `mem_write_en` drops asynchronously.

## Test plan
- After reset, `core_reset=1` and all other outputs 0. Assert `load_req`, send 0x02,0x00 then 0x13,0x00,0x00,0x00, 0x93,0x00,0x10,0x00 with continuous valid. Required response:
  - `mem_write_en` pulses twice: `PC_write=0`/`instruction_in=0x00000013`, then `PC_write=1`/`0x00100093`.
  - `load_done=1`, `core_reset=0` afterwards.
- Same stream with `byte_valid` toggled randomly (gaps of 0-3 cycles). Required: identical writes, no byte lost or duplicated, and `byte_ready=0` exactly in the WRITE cycles.
- Count 0x0000: DONE one cycle after the high byte, with no `mem_write_en` pulse.
- Count 0x0401 with PC_SIZE=10: ERROR, `load_error=1`, `core_reset=1`, no writes. Then `load_req` with count 0x0001 loads correctly and clears `load_error`.
- Count 0x0400 (=DEPTH): 1024 writes; the last has `PC_write=0x3FF`; then DONE.
- Assert `reset` after 6 bytes of a 2-word load. Required: outputs return to reset values asynchronously, and a fresh load after release completes correctly.
